// File: rtl/print_merge.sv
// print_merge: gathers the I-cache, D-cache and stats print reports into one
// ordered output stream (all I words, then all D words, then all S words).
// A one-entry output register decouples the sources from the log writer.
module print_merge #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_count,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic              i_ready,
    input  logic              d_valid,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_last,
    output logic              d_ready,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src,
    output logic              out_last,
    input  logic              out_ready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SRC_I = 3'd1,
        SRC_D = 3'd2,
        SRC_S = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_s;
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_data_r;
    logic [1:0]          out_src_r;
    logic                out_last_r;
    logic                busy_r;
    logic                done_r;
    logic [CNT_W-1:0]    word_count_r;

    logic                can_load_s;
    logic                xfer_s;
    logic [DATA_W-1:0]   xdata_s;
    logic [1:0]          xsrc_s;
    logic                xlast_s;
    logic                start_ok_s;
    logic                done_s;

    // The output register can take a new word when empty or being drained.
    assign can_load_s = ~out_valid_r | out_ready;

    // Only the source whose turn it is sees ready; the others are held off.
    assign i_ready = (state_r == SRC_I) & can_load_s;
    assign d_ready = (state_r == SRC_D) & can_load_s;
    assign s_ready = (state_r == SRC_S) & can_load_s;

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_src    = out_src_r;
    assign out_last   = out_last_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign word_count = word_count_r;

    // Next-state logic and selection of the word being transferred this cycle.
    always_comb begin
        state_s    = state_r;
        xfer_s     = 1'b0;
        xdata_s    = '0;
        xsrc_s     = 2'd0;
        xlast_s    = 1'b0;
        start_ok_s = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // A start coinciding with the done pulse is not accepted.
                if (start && !done_r) begin
                    start_ok_s = 1'b1;
                    state_s    = SRC_I;
                end else begin
                    state_s    = IDLE;
                end
            end
            SRC_I: begin
                if (i_valid && can_load_s) begin
                    xfer_s  = 1'b1;
                    xdata_s = i_data;
                    xsrc_s  = 2'd0;
                    state_s = i_last ? SRC_D : SRC_I;
                end else begin
                    state_s = SRC_I;
                end
            end
            SRC_D: begin
                if (d_valid && can_load_s) begin
                    xfer_s  = 1'b1;
                    xdata_s = d_data;
                    xsrc_s  = 2'd1;
                    state_s = d_last ? SRC_S : SRC_D;
                end else begin
                    state_s = SRC_D;
                end
            end
            SRC_S: begin
                if (s_valid && can_load_s) begin
                    xfer_s  = 1'b1;
                    xdata_s = s_data;
                    xsrc_s  = 2'd2;
                    xlast_s = s_last;
                    state_s = s_last ? DRAIN : SRC_S;
                end else begin
                    state_s = SRC_S;
                end
            end
            DRAIN: begin
                // Finish once the final word has left the output register.
                if (!out_valid_r || out_ready) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // One-entry output register: load on transfer, empty when consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_src_r   <= 2'd0;
            out_last_r  <= 1'b0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= xdata_s;
            out_src_r   <= xsrc_s;
            out_last_r  <= xlast_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Status flags and the per-print word counter (wraps naturally).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            word_count_r <= '0;
        end else begin
            done_r <= done_s;
            if (start_ok_s) begin
                busy_r <= 1'b1;
            end else if (done_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
            if (start_ok_s) begin
                word_count_r <= '0;
            end else if (xfer_s) begin
                word_count_r <= word_count_r + CNT_ONE;
            end else begin
                word_count_r <= word_count_r;
            end
        end
    end

endmodule

// File: tb/tb_print_merge.sv
// Directed bench for print_merge: queue-driven report sources, an output
// monitor that records every consumed word, and hand-computed expectations.
module tb_print_merge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  word_count;
    logic        i_valid, i_last, i_ready;
    logic [31:0] i_data;
    logic        d_valid, d_last, d_ready;
    logic [31:0] d_data;
    logic        s_valid, s_last, s_ready;
    logic [31:0] s_data;
    logic        out_valid, out_last, out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_src;

    int n_pass  = 0;
    int n_total = 0;
    int nd;

    logic [32:0] iq[$];
    logic [32:0] dq[$];
    logic [32:0] sq[$];
    logic [34:0] exp_q[$];
    logic [34:0] got_q[$];
    logic [3:0]  bp_pat = 4'b1001;

    print_merge #(.DATA_W(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .word_count(word_count),
        .i_valid(i_valid), .i_data(i_data), .i_last(i_last), .i_ready(i_ready),
        .d_valid(d_valid), .d_data(d_data), .d_last(d_last), .d_ready(d_ready),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_last(out_last), .out_ready(out_ready)
    );

    // Free-running clock.
    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_src(input int which, input logic [31:0] data, input logic last);
        case (which)
            0:       iq.push_back({last, data});
            1:       dq.push_back({last, data});
            default: sq.push_back({last, data});
        endcase
        exp_q.push_back({2'(which), (which == 2) && last, data});
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk({tag, "_word"}, 64'(got_q[k]), 64'(exp_q[k]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic run(input int ncyc, input bit bp, output int ndone);
        ndone = 0;
        for (int k = 0; k < ncyc; k++) begin
            tick();
            out_ready = bp ? bp_pat[k % 4] : 1'b1;
            @(negedge clk);
            if (done) ndone++;
        end
        out_ready = 1'b1;
    endtask

    // Stream sources: present queue heads, pop on an observed handshake.
    initial begin
        logic fi, fd, fs;
        i_valid = 1'b0; i_data = '0; i_last = 1'b0;
        d_valid = 1'b0; d_data = '0; d_last = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        forever begin
            @(negedge clk);
            fi = i_valid && i_ready;
            fd = d_valid && d_ready;
            fs = s_valid && s_ready;
            @(posedge clk);
            #2;
            if (fi && iq.size() > 0) iq.delete(0);
            if (fd && dq.size() > 0) dq.delete(0);
            if (fs && sq.size() > 0) sq.delete(0);
            if (iq.size() > 0) begin i_valid = 1'b1; {i_last, i_data} = iq[0]; end
            else begin i_valid = 1'b0; i_last = 1'b0; i_data = '0; end
            if (dq.size() > 0) begin d_valid = 1'b1; {d_last, d_data} = dq[0]; end
            else begin d_valid = 1'b0; d_last = 1'b0; d_data = '0; end
            if (sq.size() > 0) begin s_valid = 1'b1; {s_last, s_data} = sq[0]; end
            else begin s_valid = 1'b0; s_last = 1'b0; s_data = '0; end
        end
    end

    // Output monitor: logs consumed words, checks stall stability and readies.
    initial begin
        logic        stall_prev = 1'b0;
        logic [34:0] held = '0;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) got_q.push_back({out_src, out_last, out_data});
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_word", 64'({out_src, out_last, out_data}), 64'(held));
            end
            if (out_valid && !out_ready) begin
                chk("full_readies", 64'({i_ready, d_ready, s_ready}), 64'd0);
                stall_prev = 1'b1;
                held = {out_src, out_last, out_data};
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Directed test sequence.
    initial begin
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy_done", 64'({busy, done}), 64'd0);
        chk("rst_wc", 64'(word_count), 64'd0);
        chk("rst_readies", 64'({i_ready, d_ready, s_ready}), 64'd0);
        tick(); rst_n = 1'b1;

        // Basic print, cycle by cycle.
        tick();
        add_src(0, 32'hA1, 1'b0); add_src(0, 32'hA2, 1'b1); add_src(1, 32'hD1, 1'b1);
        add_src(2, 32'h51, 1'b0); add_src(2, 32'h52, 1'b1);
        start = 1'b1;
        @(negedge clk);
        chk("b_idle", 64'({busy, i_ready}), 64'd0);
        tick(); start = 1'b0;
        @(negedge clk);
        chk("b_busy_iready", 64'({busy, i_ready, out_valid}), 64'b110);
        chk("b_wc0", 64'(word_count), 64'd0);
        tick(); @(negedge clk);
        chk("b_w0", 64'({out_valid, out_src, out_last, out_data}), {29'd0, 1'b1, 2'd0, 1'b0, 32'hA1});
        chk("b_wc1", 64'(word_count), 64'd1);
        tick(); @(negedge clk);
        chk("b_w1", 64'({out_valid, out_src, out_last, out_data}), {29'd0, 1'b1, 2'd0, 1'b0, 32'hA2});
        chk("b_switch_d", 64'({i_ready, d_ready}), 64'b01);
        tick(); @(negedge clk);
        chk("b_w2", 64'({out_valid, out_src, out_last, out_data}), {29'd0, 1'b1, 2'd1, 1'b0, 32'hD1});
        chk("b_switch_s", 64'({d_ready, s_ready}), 64'b01);
        tick(); @(negedge clk);
        chk("b_w3", 64'({out_valid, out_src, out_last, out_data}), {29'd0, 1'b1, 2'd2, 1'b0, 32'h51});
        tick(); @(negedge clk);
        chk("b_w4", 64'({out_valid, out_src, out_last, out_data}), {29'd0, 1'b1, 2'd2, 1'b1, 32'h52});
        chk("b_drain", 64'({busy, done, s_ready}), 64'b100);
        tick(); start = 1'b1;
        @(negedge clk);
        chk("b_done", 64'({busy, done, out_valid}), 64'b010);
        chk("b_wc5", 64'(word_count), 64'd5);
        tick(); start = 1'b0;
        @(negedge clk);
        chk("b_start_at_done_ignored", 64'({busy, done, i_ready}), 64'd0);
        cmp_q("basic");

        // Early D and S sources must wait for their turn.
        tick();
        add_src(0, 32'hB1, 1'b0); add_src(0, 32'hB2, 1'b0); add_src(0, 32'hB3, 1'b1);
        add_src(1, 32'hD7, 1'b1); add_src(2, 32'h57, 1'b1);
        start = 1'b1;
        @(negedge clk);
        chk("e_hold0", 64'({d_ready, s_ready}), 64'd0);
        tick(); start = 1'b0;
        @(negedge clk);
        chk("e_hold1", 64'({i_ready, d_ready, s_ready}), 64'b100);
        tick(); @(negedge clk);
        chk("e_hold2", 64'({d_ready, s_ready}), 64'd0);
        tick(); @(negedge clk);
        chk("e_hold3", 64'({d_ready, s_ready}), 64'd0);
        tick(); @(negedge clk);
        chk("e_d_turn", 64'({d_ready, s_ready}), 64'b10);
        tick(); @(negedge clk);
        chk("e_s_turn", 64'({d_ready, s_ready}), 64'b01);
        run(15, 1'b0, nd);
        chk("e_done_count", 64'(nd), 64'd1);
        chk("e_wc", 64'(word_count), 64'd5);
        cmp_q("early");

        // Backpressure with out_ready pattern 1,0,0,1.
        tick();
        add_src(0, 32'hC1, 1'b0); add_src(0, 32'hC2, 1'b0); add_src(0, 32'hC3, 1'b1);
        add_src(1, 32'hE1, 1'b0); add_src(1, 32'hE2, 1'b1); add_src(2, 32'hF1, 1'b1);
        start = 1'b1;
        tick(); start = 1'b0;
        run(60, 1'b1, nd);
        chk("bp_done_count", 64'(nd), 64'd1);
        chk("bp_wc", 64'(word_count), 64'd6);
        cmp_q("bp");

        // Second start pulse while in SRC_D is ignored.
        tick();
        add_src(0, 32'h11, 1'b1);
        add_src(1, 32'h21, 1'b0); add_src(1, 32'h22, 1'b0); add_src(1, 32'h23, 1'b1);
        add_src(2, 32'h31, 1'b1);
        start = 1'b1;
        tick(); start = 1'b0;
        tick(); start = 1'b1;
        @(negedge clk);
        chk("sb_in_d", 64'({busy, d_ready}), 64'b11);
        tick(); start = 1'b0;
        run(20, 1'b0, nd);
        chk("sb_done_count", 64'(nd), 64'd1);
        chk("sb_wc", 64'(word_count), 64'd5);
        chk("sb_idle_after", 64'(busy), 64'd0);
        cmp_q("sb");

        // Asynchronous reset in the middle of the D report.
        tick();
        add_src(0, 32'h41, 1'b1);
        add_src(1, 32'h42, 1'b0); add_src(1, 32'h43, 1'b0); add_src(1, 32'h44, 1'b1);
        add_src(2, 32'h45, 1'b1);
        start = 1'b1;
        tick(); start = 1'b0;
        tick(); @(negedge clk);
        chk("r_pre", 64'({out_valid, d_ready}), 64'b11);
        tick();
        iq.delete(); dq.delete(); sq.delete();
        rst_n = 1'b0;
        #1;
        chk("r_out", 64'({out_valid, out_src, out_last, out_data}), 64'd0);
        chk("r_flags", 64'({busy, done, word_count}), 64'd0);
        chk("r_readies", 64'({i_ready, d_ready, s_ready}), 64'd0);
        tick(); tick(); rst_n = 1'b1;
        got_q.delete(); exp_q.delete();
        tick();
        add_src(0, 32'h61, 1'b1); add_src(1, 32'h62, 1'b1);
        add_src(2, 32'h63, 1'b0); add_src(2, 32'h64, 1'b1);
        start = 1'b1;
        tick(); start = 1'b0;
        run(20, 1'b0, nd);
        chk("r_done_count", 64'(nd), 64'd1);
        chk("r_wc", 64'(word_count), 64'd4);
        cmp_q("r_after");

        // Counter wrap: 17 + 1 + 1 = 19 words, 4-bit counter reads 3.
        tick();
        for (int k = 0; k < 17; k++) add_src(0, 32'h100 + k, k == 16);
        add_src(1, 32'h200, 1'b1);
        add_src(2, 32'h300, 1'b1);
        start = 1'b1;
        tick(); start = 1'b0;
        run(40, 1'b0, nd);
        chk("w_done_count", 64'(nd), 64'd1);
        chk("w_wc", 64'(word_count), 64'd3);
        cmp_q("wrap");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
